vc_grant_dispatcher: RTL and testbench

Consumer side of the QoS VC arbiter. Holds four per-VC FIFOs (VC0..VC3) filled by the transaction layer. Takes the arbiter's one-hot 4-bit grant and dequeues one entry from the granted VC into a registered output stage with a valid/ready handshake toward the link layer. Returns per-VC request (non-empty) flags to the arbiter.

---
 rtl/vc_grant_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_vc_grant_dispatcher.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_grant_dispatcher.sv
// vc_grant_dispatcher
// Consumer side of the QoS VC arbiter. Four per-VC FIFOs are filled by the
// transaction layer; the arbiter's one-hot grant dequeues one entry per cycle
// into a registered valid/ready output stage toward the link layer. Per-VC
// non-empty (req) and full flags are returned combinationally from the counts.

module vc_grant_dispatcher #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [1:0]        wr_vc,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        grant,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_vc,
    output logic [3:0]        req,
    output logic [3:0]        full,
    output logic              wr_drop,
    output logic              grant_err
);

    localparam int              NUM_VC   = 4;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    // FIFO storage and per-VC bookkeeping
    logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr [NUM_VC];
    logic [ADDR_W-1:0] r_rd_ptr [NUM_VC];
    logic [ADDR_W:0]   r_count  [NUM_VC];

    // Registered output stage and status pulses
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_vc;
    logic              r_wr_drop;
    logic              r_grant_err;

    // Decoded control
    logic       w_grant_onehot;
    logic [1:0] w_grant_vc;
    logic       w_grant_nonempty;
    logic       w_can_load;
    logic       w_pop;
    logic       w_grant_err;
    logic       w_wr_full;
    logic       w_push;
    logic       w_drop;

    // Decode the grant into a VC index and legality flag.
    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_grant_onehot = 1'b0;
        w_grant_vc     = 2'd0;
        case (grant)
            4'b0001: begin w_grant_onehot = 1'b1; w_grant_vc = 2'd0; end
            4'b0010: begin w_grant_onehot = 1'b1; w_grant_vc = 2'd1; end
            4'b0100: begin w_grant_onehot = 1'b1; w_grant_vc = 2'd2; end
            4'b1000: begin w_grant_onehot = 1'b1; w_grant_vc = 2'd3; end
            default: ;
        endcase
    end

    // Pop/push qualification. A full VC still accepts a push when the same
    // cycle pops it, since the pop frees the slot being written.
    always_comb begin
        w_grant_nonempty = (r_count[w_grant_vc] != '0);
        w_can_load       = !r_out_valid || out_ready;
        w_pop            = w_grant_onehot && w_grant_nonempty && w_can_load;
        w_grant_err      = ((grant != 4'b0000) && !w_grant_onehot)
                         || (w_grant_onehot && !w_grant_nonempty);
        w_wr_full        = (r_count[wr_vc] == FULL_CNT);
        w_push           = wr_en && (!w_wr_full || (w_pop && (w_grant_vc == wr_vc)));
        w_drop           = wr_en && !w_push;
    end

    // Payload write port.
    // NOTE: storage has no reset; contents are only observable through a
    // pointer/count pair, and those are reset, so stale data is never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[wr_vc][r_wr_ptr[wr_vc]] <= wr_data;
        end
    end

    // Per-VC pointer and occupancy update.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, matching the hardware it describes.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                logic push_v;
                logic pop_v;
                push_v = w_push && (wr_vc == 2'(v));
                pop_v  = w_pop && (w_grant_vc == 2'(v));
                if (push_v) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + 1'b1;
                end
                if (pop_v) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + 1'b1;
                end
                case ({push_v, pop_v})
                    2'b10:   r_count[v] <= r_count[v] + 1'b1;
                    2'b01:   r_count[v] <= r_count[v] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Output stage: load on pop, retire on accept, hold under backpressure.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_vc    <= 2'd0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[w_grant_vc][r_rd_ptr[w_grant_vc]];
            r_out_vc    <= w_grant_vc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // One-cycle status pulses reporting the previous cycle's push and grant.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_drop   <= 1'b0;
            r_grant_err <= 1'b0;
        end else begin
            r_wr_drop   <= w_drop;
            r_grant_err <= w_grant_err;
        end
    end

    // Arbiter-facing flags follow the current counts directly.
    always_comb begin
        req  = 4'b0000;
        full = 4'b0000;
        for (int v = 0; v < NUM_VC; v++) begin
            req[v]  = (r_count[v] != '0);
            full[v] = (r_count[v] == FULL_CNT);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_vc    = r_out_vc;
    assign wr_drop   = r_wr_drop;
    assign grant_err = r_grant_err;

endmodule

// File: tb/tb_vc_grant_dispatcher.sv
// Directed testbench for vc_grant_dispatcher. Inputs are driven and outputs
// sampled 1 ns after the rising edge; each scenario task checks inline.

module tb_vc_grant_dispatcher;

    localparam int DATA_W = 8;

    logic              clk;
    logic              reset_L;
    logic              wr_en;
    logic [1:0]        wr_vc;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        grant;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_vc;
    logic [3:0]        req;
    logic [3:0]        full;
    logic              wr_drop;
    logic              grant_err;

    int n_checks = 0;
    int n_errors = 0;

    vc_grant_dispatcher #(.DATA_W(DATA_W), .DEPTH(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .wr_en     (wr_en),
        .wr_vc     (wr_vc),
        .wr_data   (wr_data),
        .grant     (grant),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_vc    (out_vc),
        .req       (req),
        .full      (full),
        .wr_drop   (wr_drop),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] vc, input logic [7:0] d);
        wr_en = 1'b1; wr_vc = vc; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0; wr_en = 1'b0; wr_vc = 2'd0; wr_data = 8'h00;
        grant = 4'b0000; out_ready = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data, out_vc, req, full, wr_drop, grant_err} !== 20'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h vc=%0d req=%b full=%b drop=%b gerr=%b, want all zero",
                     out_valid, out_data, out_vc, req, full, wr_drop, grant_err);
        end
        tick(); tick();
        reset_L = 1'b1;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || req !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_idle: got valid=%b req=%b, want valid=0 req=0000", out_valid, req);
        end
    endtask

    task automatic test_fill_drain_vc2();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) push(2'd2, 8'hA1 + 8'(i));
        n_checks++;
        if (full !== 4'b0100 || req !== 4'b0100) begin
            n_errors++;
            $display("FAIL fill_vc2_flags: got full=%b req=%b, want full=0100 req=0100", full, req);
        end
        push(2'd2, 8'hA5);
        n_checks++;
        if (wr_drop !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_drop: got wr_drop=%b, want 1", wr_drop);
        end
        tick();
        n_checks++;
        if (wr_drop !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_pulse_width: got wr_drop=%b, want 0", wr_drop);
        end
        grant = 4'b0100; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = 8'hA1 + 8'(i);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_vc !== 2'd2) begin
                n_errors++;
                $display("FAIL drain_vc2[%0d]: got valid=%b data=%h vc=%0d, want valid=1 data=%h vc=2",
                         i, out_valid, out_data, out_vc, exp_d);
            end
        end
        grant = 4'b0000;
        n_checks++;
        if (req !== 4'b0000 || full !== 4'b0000) begin
            n_errors++;
            $display("FAIL drain_vc2_empty: got req=%b full=%b, want 0000/0000 (A5 must be lost)", req, full);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || grant_err !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_vc2_retire: got valid=%b gerr=%b, want 0/0", out_valid, grant_err);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) push(2'(i), 8'h10 + 8'(i));
        n_checks++;
        if (req !== 4'b1111) begin
            n_errors++;
            $display("FAIL rr_req: got req=%b, want 1111", req);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            grant = 4'b0001 << i;
            tick();
            exp_d = 8'h10 + 8'(i);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_vc !== 2'(i)) begin
                n_errors++;
                $display("FAIL rr_stream[%0d]: got valid=%b data=%h vc=%0d, want valid=1 data=%h vc=%0d",
                         i, out_valid, out_data, out_vc, exp_d, i);
            end
        end
        grant = 4'b0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || req !== 4'b0000) begin
            n_errors++;
            $display("FAIL rr_end: got valid=%b req=%b, want 0/0000", out_valid, req);
        end
    endtask

    task automatic test_backpressure();
        push(2'd0, 8'h10);
        push(2'd1, 8'h21);
        grant = 4'b0001; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; grant = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 || out_vc !== 2'd0 || req !== 4'b0010 || grant_err !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h vc=%0d req=%b gerr=%b, want 1/10/0/0010/0",
                         i, out_valid, out_data, out_vc, req, grant_err);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h21 || out_vc !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_release: got valid=%b data=%h vc=%0d, want 1/21/1", out_valid, out_data, out_vc);
        end
        grant = 4'b0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || req !== 4'b0000) begin
            n_errors++;
            $display("FAIL bp_end: got valid=%b req=%b, want 0/0000", out_valid, req);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d;
        // VC0 pointers sit at 2 here, so this fill wraps the pointers.
        for (int i = 0; i < 4; i++) push(2'd0, 8'hB0 + 8'(i));
        n_checks++;
        if (full !== 4'b0001) begin
            n_errors++;
            $display("FAIL fpp_full: got full=%b, want 0001", full);
        end
        grant = 4'b0001; out_ready = 1'b1; wr_en = 1'b1; wr_vc = 2'd0;
        for (int i = 0; i < 2; i++) begin
            wr_data = 8'hB4 + 8'(i);
            tick();
            exp_d = 8'hB0 + 8'(i);
            n_checks++;
            if (wr_drop !== 1'b0 || full !== 4'b0001 || out_data !== exp_d || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL fpp_simul[%0d]: got drop=%b full=%b valid=%b data=%h, want 0/0001/1/%h",
                         i, wr_drop, full, out_valid, out_data, exp_d);
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = 8'hB2 + 8'(i);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_vc !== 2'd0) begin
                n_errors++;
                $display("FAIL fpp_order[%0d]: got valid=%b data=%h vc=%0d, want 1/%h/0",
                         i, out_valid, out_data, out_vc, exp_d);
            end
        end
        grant = 4'b0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || req !== 4'b0000 || full !== 4'b0000) begin
            n_errors++;
            $display("FAIL fpp_end: got valid=%b req=%b full=%b, want 0/0000/0000", out_valid, req, full);
        end
    endtask

    task automatic test_illegal_grant();
        push(2'd0, 8'h55);
        push(2'd1, 8'h66);
        out_ready = 1'b1; grant = 4'b0011;
        tick();
        n_checks++;
        if (grant_err !== 1'b1 || out_valid !== 1'b0 || req !== 4'b0011) begin
            n_errors++;
            $display("FAIL multi_grant: got gerr=%b valid=%b req=%b, want 1/0/0011", grant_err, out_valid, req);
        end
        grant = 4'b0000;
        tick();
        n_checks++;
        if (grant_err !== 1'b0) begin
            n_errors++;
            $display("FAIL gerr_pulse: got gerr=%b, want 0", grant_err);
        end
        grant = 4'b0001;
        tick();
        out_ready = 1'b0; grant = 4'b1000;
        tick();
        n_checks++;
        if (grant_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h55 || req !== 4'b0010) begin
            n_errors++;
            $display("FAIL empty_grant: got gerr=%b valid=%b data=%h req=%b, want 1/1/55/0010",
                     grant_err, out_valid, out_data, req);
        end
        out_ready = 1'b1; grant = 4'b0010;
        tick();
        n_checks++;
        if (grant_err !== 1'b0 || out_data !== 8'h66 || out_vc !== 2'd1) begin
            n_errors++;
            $display("FAIL after_err: got gerr=%b data=%h vc=%0d, want 0/66/1", grant_err, out_data, out_vc);
        end
        // Push and grant on an empty VC together: the grant errors, the push lands.
        wr_en = 1'b1; wr_vc = 2'd2; wr_data = 8'h77; grant = 4'b0100;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (grant_err !== 1'b1 || out_valid !== 1'b0 || req !== 4'b0100) begin
            n_errors++;
            $display("FAIL empty_push_pop: got gerr=%b valid=%b req=%b, want 1/0/0100", grant_err, out_valid, req);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || out_vc !== 2'd2 || grant_err !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_push_then_pop: got valid=%b data=%h vc=%0d gerr=%b, want 1/77/2/0",
                     out_valid, out_data, out_vc, grant_err);
        end
        grant = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midop();
        push(2'd1, 8'hC1);
        push(2'd3, 8'hC3);
        push(2'd1, 8'hC2);
        out_ready = 1'b0; grant = 4'b0010;
        tick();
        grant = 4'b0000;
        #2;
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data, out_vc, req, full, wr_drop, grant_err} !== 20'h0) begin
            n_errors++;
            $display("FAIL midop_reset: got valid=%b data=%h vc=%0d req=%b full=%b drop=%b gerr=%b, want all zero",
                     out_valid, out_data, out_vc, req, full, wr_drop, grant_err);
        end
        #3;
        reset_L = 1'b1;
        out_ready = 1'b1;
        tick();
        grant = 4'b0010;
        tick();
        grant = 4'b0000;
        n_checks++;
        if (grant_err !== 1'b1 || out_valid !== 1'b0 || req !== 4'b0000) begin
            n_errors++;
            $display("FAIL midop_discard: got gerr=%b valid=%b req=%b, want 1/0/0000", grant_err, out_valid, req);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain_vc2();
        test_round_robin();
        test_backpressure();
        test_full_push_pop();
        test_illegal_grant();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
